// File: rtl/analog_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : analog_axis_arbiter
// Purpose  : Player-1 analog axis source select between the HPS analog stick
//            and PS/2 mouse emulation (saturating absolute position), with
//            centre-and-freeze while the CPU is halted by the OSD/menu.
// Revision : 1.0 - initial release
// ============================================================================
module analog_axis_arbiter #(
  parameter int DELTA_LIMIT  = 10,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joya,
  input  logic [15:0] joy,
  input  logic        cpu_halt,
  output logic [7:0]  ax,
  output logic [7:0]  ay,
  output logic [15:0] joy_out,
  output logic        mouse_active,
  output logic        axis_upd
);

  // Idle counter is sized to hold IDLE_TIMEOUT; a 1-bit stub when disabled.
  localparam int                    c_idle_w   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [c_idle_w-1:0]   c_idle_max = c_idle_w'(IDLE_TIMEOUT);
  localparam logic signed [8:0]     c_lim      = 9'(DELTA_LIMIT);

  typedef enum logic [1:0] {
    S_JOY   = 2'd0,
    S_MOUSE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_stb_d;
  logic                  r_armed;
  logic signed [7:0]     r_mx;
  logic signed [7:0]     r_my;
  logic [c_idle_w-1:0]   r_idle;

  logic                  w_event;
  logic                  w_joya_nz;
  logic signed [8:0]     w_dx;
  logic signed [8:0]     w_dy;
  logic signed [7:0]     w_base_x;
  logic signed [7:0]     w_base_y;
  logic signed [7:0]     w_mx_new;
  logic signed [7:0]     w_my_new;
  logic [c_idle_w-1:0]   w_idle_inc;
  logic                  w_idle_hit;
  logic [7:0]            w_ax_n;
  logic [7:0]            w_ay_n;
  logic [15:0]           w_joy_n;
  logic                  w_act_n;
  logic                  w_unused;

  // Limit one mouse report to +/-DELTA_LIMIT so a burst cannot jump the cursor.
  function automatic logic signed [8:0] clamp_d(input logic signed [8:0] d);
    if (d > c_lim)
      return c_lim;
    else if (d < -c_lim)
      return -c_lim;
    else
      return d;
  endfunction

  // 10-bit add then pin to the signed 8-bit range; the position never wraps.
  function automatic logic signed [7:0] sat_add(input logic signed [7:0] acc,
                                                input logic signed [8:0] d);
    logic signed [9:0] n;
    n = {{2{acc[7]}}, acc} + {d[8], d};
    if (n > 10'sd127)
      return 8'sd127;
    else if (n < -10'sd128)
      return 8'h80;
    else
      return n[7:0];
  endfunction

  // The first edge after reset only captures the strobe level, so a toggle
  // that happened while in reset is never replayed as an event.
  assign w_event   = r_armed && (ps2_mouse[24] != r_stb_d);
  assign w_joya_nz = |joya;

  // PS/2 reports up as positive Y; the console wants up as negative.
  assign w_dx      = clamp_d({ps2_mouse[4], ps2_mouse[15:8]});
  assign w_dy      = -clamp_d({ps2_mouse[5], ps2_mouse[23:16]});

  // Entering MOUSE starts from the centre; inside MOUSE it accumulates.
  assign w_base_x  = (r_state == S_MOUSE) ? r_mx : 8'sd0;
  assign w_base_y  = (r_state == S_MOUSE) ? r_my : 8'sd0;
  assign w_mx_new  = sat_add(w_base_x, w_dx);
  assign w_my_new  = sat_add(w_base_y, w_dy);

  assign w_idle_inc = (r_idle == c_idle_max) ? r_idle : r_idle + 1'b1;
  assign w_idle_hit = (IDLE_TIMEOUT != 0) && (w_idle_inc == c_idle_max);

  // Mouse bits that carry no information for the console.
  assign w_unused  = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Output selection: halt and a live stick take effect at once, mouse
  // position is shown one edge after the event that produced it.
  always_comb begin
    w_ax_n  = joya[7:0];
    w_ay_n  = joya[15:8];
    w_joy_n = joy;
    w_act_n = 1'b0;
    if (cpu_halt || (r_state == S_HALT)) begin
      w_ax_n = 8'h00;
      w_ay_n = 8'h00;
    end else if ((r_state == S_MOUSE) && !w_joya_nz) begin
      w_ax_n  = r_mx;
      w_ay_n  = r_my;
      w_joy_n = {joy[15:6], ps2_mouse[1:0], joy[3:0]};
      w_act_n = 1'b1;
    end
  end

  // Source arbitration state machine with registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= S_JOY;
      r_stb_d      <= 1'b0;
      r_armed      <= 1'b0;
      r_mx         <= 8'sd0;
      r_my         <= 8'sd0;
      r_idle       <= '0;
      ax           <= 8'h00;
      ay           <= 8'h00;
      joy_out      <= 16'h0000;
      mouse_active <= 1'b0;
      axis_upd     <= 1'b0;
    end else begin
      r_armed      <= 1'b1;
      r_stb_d      <= ps2_mouse[24];
      ax           <= w_ax_n;
      ay           <= w_ay_n;
      joy_out      <= w_joy_n;
      mouse_active <= w_act_n;
      axis_upd     <= ({w_ax_n, w_ay_n} != {ax, ay});

      if (cpu_halt) begin
        r_state <= S_HALT;
        r_mx    <= 8'sd0;
        r_my    <= 8'sd0;
        r_idle  <= '0;
      end else begin
        case (r_state)
          S_HALT: begin
            r_state <= S_JOY;
            r_idle  <= '0;
          end
          S_JOY: begin
            r_idle <= '0;
            if (w_event && !w_joya_nz) begin
              r_state <= S_MOUSE;
              r_mx    <= w_mx_new;
              r_my    <= w_my_new;
            end
          end
          S_MOUSE: begin
            if (w_joya_nz) begin
              r_state <= S_JOY;
              r_mx    <= 8'sd0;
              r_my    <= 8'sd0;
              r_idle  <= '0;
            end else if (w_event) begin
              r_mx   <= w_mx_new;
              r_my   <= w_my_new;
              r_idle <= '0;
            end else if (w_idle_hit) begin
              r_state <= S_JOY;
              r_mx    <= 8'sd0;
              r_my    <= 8'sd0;
              r_idle  <= '0;
            end else begin
              r_idle <= w_idle_inc;
            end
          end
          default: begin
            r_state <= S_JOY;
            r_mx    <= 8'sd0;
            r_my    <= 8'sd0;
            r_idle  <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_analog_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_analog_axis_arbiter
// Purpose  : Self-checking bench for analog_axis_arbiter (IDLE_TIMEOUT 0 and 8
//            instances driven in parallel) against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_analog_axis_arbiter;

  localparam int DL      = 10;
  localparam int M_JOY   = 0;
  localparam int M_MOUSE = 1;
  localparam int M_HALT  = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [15:0] joya;
  logic [15:0] joy;
  logic        cpu_halt;

  logic [7:0]  ax_0, ay_0, ax_8, ay_8;
  logic [15:0] jo_0, jo_8;
  logic        ma_0, ma_8, up_0, up_8;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model, index 0 = no idle fallback, index 1 = 8-cycle fallback
  int          m_mode [2];
  int          m_mx   [2];
  int          m_my   [2];
  int          m_idle [2];
  int          m_ax   [2];
  int          m_ay   [2];
  logic [15:0] m_jo   [2];
  logic        m_ma   [2];
  logic        m_up   [2];
  logic        m_stbd [2];
  logic        m_armed[2];

  analog_axis_arbiter #(.DELTA_LIMIT(DL), .IDLE_TIMEOUT(0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy(joy), .cpu_halt(cpu_halt), .ax(ax_0), .ay(ay_0), .joy_out(jo_0),
    .mouse_active(ma_0), .axis_upd(up_0)
  );

  analog_axis_arbiter #(.DELTA_LIMIT(DL), .IDLE_TIMEOUT(8)) dut8 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy(joy), .cpu_halt(cpu_halt), .ax(ax_8), .ay(ay_8), .joy_out(jo_8),
    .mouse_active(ma_8), .axis_upd(up_8)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int clampd(int d);
    if (d > DL)  return DL;
    if (d < -DL) return -DL;
    return d;
  endfunction

  function automatic int sat8(int n);
    if (n > 127)  return 127;
    if (n < -128) return -128;
    return n;
  endfunction

  function automatic int s9(logic s, logic [7:0] b);
    return s ? int'(b) - 256 : int'(b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_JOY; m_mx[k] = 0; m_my[k] = 0; m_idle[k] = 0;
      m_ax[k] = 0; m_ay[k] = 0; m_jo[k] = 16'h0; m_ma[k] = 1'b0; m_up[k] = 1'b0;
      m_stbd[k] = 1'b0; m_armed[k] = 1'b0;
    end
  endtask

  task automatic model_edge(int k, int tmo);
    int dx, dy, nax, nay;
    logic [15:0] njo;
    logic nma;
    bit ev, jnz;
    ev  = m_armed[k] && (ps2_mouse[24] != m_stbd[k]);
    jnz = (joya != 16'h0);
    dx  = clampd(s9(ps2_mouse[4], ps2_mouse[15:8]));
    dy  = -clampd(s9(ps2_mouse[5], ps2_mouse[23:16]));
    if (cpu_halt || m_mode[k] == M_HALT) begin
      nax = 0; nay = 0; njo = joy; nma = 1'b0;
    end else if (m_mode[k] == M_MOUSE && !jnz) begin
      nax = m_mx[k]; nay = m_my[k]; njo = {joy[15:6], ps2_mouse[1:0], joy[3:0]}; nma = 1'b1;
    end else begin
      nax = int'($signed(joya[7:0])); nay = int'($signed(joya[15:8])); njo = joy; nma = 1'b0;
    end
    m_up[k] = (8'(nax) != 8'(m_ax[k])) || (8'(nay) != 8'(m_ay[k]));
    m_ax[k] = nax; m_ay[k] = nay; m_jo[k] = njo; m_ma[k] = nma;
    if (cpu_halt) begin
      m_mode[k] = M_HALT; m_mx[k] = 0; m_my[k] = 0; m_idle[k] = 0;
    end else if (m_mode[k] == M_HALT) begin
      m_mode[k] = M_JOY;
    end else if (m_mode[k] == M_JOY) begin
      if (ev && !jnz) begin
        m_mode[k] = M_MOUSE; m_mx[k] = sat8(dx); m_my[k] = sat8(dy); m_idle[k] = 0;
      end
    end else begin
      if (jnz) begin
        m_mode[k] = M_JOY; m_mx[k] = 0; m_my[k] = 0; m_idle[k] = 0;
      end else if (ev) begin
        m_mx[k] = sat8(m_mx[k] + dx); m_my[k] = sat8(m_my[k] + dy); m_idle[k] = 0;
      end else if (tmo != 0) begin
        m_idle[k] = m_idle[k] + 1;
        if (m_idle[k] >= tmo) begin
          m_mode[k] = M_JOY; m_mx[k] = 0; m_my[k] = 0; m_idle[k] = 0;
        end
      end
    end
    m_armed[k] = 1'b1;
    m_stbd[k]  = ps2_mouse[24];
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ax0",  {8'h0, ax_0}, {8'h0, 8'(m_ax[0])});
    chk("ay0",  {8'h0, ay_0}, {8'h0, 8'(m_ay[0])});
    chk("jo0",  jo_0, m_jo[0]);
    chk("ma0",  {15'h0, ma_0}, {15'h0, m_ma[0]});
    chk("upd0", {15'h0, up_0}, {15'h0, m_up[0]});
    chk("ax8",  {8'h0, ax_8}, {8'h0, 8'(m_ax[1])});
    chk("ay8",  {8'h0, ay_8}, {8'h0, 8'(m_ay[1])});
    chk("jo8",  jo_8, m_jo[1]);
    chk("ma8",  {15'h0, ma_8}, {15'h0, m_ma[1]});
    chk("upd8", {15'h0, up_8}, {15'h0, m_up[1]});
  endtask

  task automatic step();
    @(posedge clk_sys);
    if (reset) model_reset();
    else begin
      model_edge(0, 0);
      model_edge(1, 8);
    end
    #1;
    check_all();
  endtask

  // dy is in PS/2 orientation (up positive); the strobe toggles each call.
  task automatic set_mouse(int dx, int dy, logic [1:0] btn);
    logic [8:0] vx, vy;
    vx = 9'(dx);
    vy = 9'(dy);
    ps2_mouse = {~ps2_mouse[24], vy[7:0], vx[7:0], 2'b00, vy[8], vx[8], 2'b00, btn};
  endtask

  initial begin
    reset = 1'b0; ps2_mouse = '0; joya = 16'h3AC5; joy = 16'h1234; cpu_halt = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_all();
    @(negedge clk_sys);
    step();
    @(negedge clk_sys);
    reset = 1'b0;

    // Stick passes straight through after one edge
    step();
    chk("tp_reset_ax", {8'h0, ax_0}, 16'h00C5);
    chk("tp_reset_ay", {8'h0, ay_0}, 16'h003A);
    chk("tp_reset_ma", {15'h0, ma_0}, 16'h0000);
    chk("tp_reset_jo", jo_0, 16'h1234);

    // Mouse takes over from a centred stick, two-edge latency
    joya = 16'h0;
    step();
    set_mouse(4, 3, 2'b10);
    step();
    chk("tp_lat_ax", {8'h0, ax_0}, 16'h0000);
    step();
    chk("tp_m_ax",  {8'h0, ax_0}, 16'h0004);
    chk("tp_m_ay",  {8'h0, ay_0}, 16'h00FD);
    chk("tp_m_ma",  {15'h0, ma_0}, 16'h0001);
    chk("tp_m_upd", {15'h0, up_0}, 16'h0001);
    chk("tp_m_btn", {14'h0, jo_0[5:4]}, 16'h0002);
    step();
    chk("tp_m_upd_once", {15'h0, up_0}, 16'h0000);

    // Clamped deltas saturate X at 127
    for (int i = 0; i < 20; i++) begin
      set_mouse(100, 0, 2'b10);
      step();
    end
    step();
    chk("tp_sat_ax", {8'h0, ax_0}, 16'h007F);
    chk("tp_sat_upd", {15'h0, up_0}, 16'h0000);

    // Large negative delta moves by exactly the limit
    set_mouse(-100, 0, 2'b01);
    step();
    step();
    chk("tp_neg_ax", {8'h0, ax_0}, 16'h0075);

    // Walk X to 50, then a live stick with a coincident event wins
    for (int i = 0; i < 6; i++) begin
      set_mouse(-10, 0, 2'b01);
      step();
    end
    set_mouse(-7, 0, 2'b01);
    step();
    step();
    chk("tp_50_ax", {8'h0, ax_0}, 16'h0032);
    joya = 16'h0010;
    set_mouse(5, 5, 2'b11);
    step();
    chk("tp_joy_ax", {8'h0, ax_0}, 16'h0010);
    chk("tp_joy_ay", {8'h0, ay_0}, 16'h0000);
    chk("tp_joy_ma", {15'h0, ma_0}, 16'h0000);
    joya = 16'h0;
    step();
    set_mouse(5, 0, 2'b00);
    step();
    step();
    chk("tp_restart_ax", {8'h0, ax_0}, 16'h0005);

    // Halt centres and freezes, then falls back to the stick
    set_mouse(10, 0, 2'b00); step();
    set_mouse(10, 0, 2'b00); step();
    set_mouse(5, 0, 2'b00);  step();
    step();
    chk("tp_30_ax", {8'h0, ax_0}, 16'h001E);
    cpu_halt = 1'b1;
    set_mouse(7, 7, 2'b00);
    step();
    chk("tp_halt_ax", {8'h0, ax_0}, 16'h0000);
    chk("tp_halt_ay", {8'h0, ay_0}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      set_mouse(7, 7, 2'b00);
      step();
    end
    chk("tp_halt_hold", {ax_0, ay_0}, 16'h0000);
    cpu_halt = 1'b0;
    step();
    step();
    chk("tp_unhalt_ma", {15'h0, ma_0}, 16'h0000);

    // Idle fallback on the IDLE_TIMEOUT=8 instance only
    set_mouse(3, 0, 2'b00);
    step();
    for (int i = 0; i < 8; i++) step();
    chk("tp_idle_pre8", {15'h0, ma_8}, 16'h0001);
    step();
    chk("tp_idle_ma8", {15'h0, ma_8}, 16'h0000);
    chk("tp_idle_ma0", {15'h0, ma_0}, 16'h0001);
    chk("tp_idle_ax0", {8'h0, ax_0}, 16'h0003);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cpu_halt = ($urandom_range(0, 15) == 0);
      joya     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      joy      = 16'($urandom);
      if ((i % 64 < 40) && ($urandom_range(0, 1) == 1))
        set_mouse(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                  2'($urandom));
      else
        ps2_mouse[1:0] = 2'($urandom);
      step();
    end

    // Reset in the middle of MOUSE clears outputs immediately
    cpu_halt = 1'b0;
    joya = 16'h0;
    step();
    step();
    set_mouse(2, 2, 2'b11);
    step();
    step();
    chk("tp_pre_rst_ma", {15'h0, ma_0}, 16'h0001);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("tp_rst_ax", {8'h0, ax_0}, 16'h0000);
    chk("tp_rst_ma", {15'h0, ma_0}, 16'h0000);
    set_mouse(4, 4, 2'b00);
    step();
    @(negedge clk_sys);
    reset = 1'b0;
    step();
    step();
    chk("tp_no_replay_ma", {15'h0, ma_0}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/analog_axis_arbiter.md
Name: analog_axis_arbiter

Overview:
- Owns the player-1 analog axis pair fed to atari5200top (JOY1X/JOY1Y) and the digital word fed to JOY1.
- Arbitrates between two sources:
  - the HPS analog joystick;
  - PS/2 mouse emulation, where mouse deltas are accumulated into a saturating absolute position.
- Centres and freezes the axes while the CPU is halted (OSD/menu).
- Sits in emu between hps_io and atari5200top, in the clk_sys domain.

Parameters:
- DELTA_LIMIT, 10: maximum magnitude of a single mouse delta after clamping.
- IDLE_TIMEOUT, 0: clk_sys cycles without mouse activity before the block falls back to JOY. 0 disables the fallback.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ps2_mouse, in, 25: hps_io mouse word.
  - [24] toggle strobe.
  - [1:0] left/right buttons.
  - [4] X sign, [5] Y sign.
  - [15:8] dX, [23:16] dY.
- joya, in, 16: analog stick. [7:0] X signed, [15:8] Y signed.
- joy, in, 16: digital joystick/buttons word.
- cpu_halt, in, 1: CPU halted (menu active).
- ax, out, 8: signed X to JOY1X.
- ay, out, 8: signed Y to JOY1Y.
- joy_out, out, 16: digital word to JOY1.
- mouse_active, out, 1: high while state is MOUSE.
- axis_upd, out, 1: one-cycle pulse whenever ax or ay changes value.

Behaviour:
- Reset (async assert, released synchronously to clk_sys):
  - state = JOY; accumulators mx = my = 0; stb_d = ps2_mouse[24] sampled at the first edge after release.
  - ax = ay = 0, joy_out = 0, mouse_active = 0, axis_upd = 0, idle counter = 0.
- Mouse event:
  - An event is `ps2_mouse[24] != stb_d` at a clk_sys edge. stb_d updates every cycle.
  - The event is consumed at that edge. Resulting ax/ay and axis_upd are visible after the next edge (latency 2 edges from strobe toggle to outputs).
- Delta arithmetic:
  - dx9 = {ps2_mouse[4], ps2_mouse[15:8]}, 9-bit signed. Clamp to [-DELTA_LIMIT, +DELTA_LIMIT].
  - dy9 is built the same way from [5] and [23:16], clamped, then negated (PS/2 up = Atari negative Y).
  - Accumulate in 10 bits: n = acc + delta. Saturate to [-128, 127]; never wrap.
- States:
  - JOY:
    - ax = joya[7:0], ay = joya[15:8], registered.
    - Go to MOUSE on a mouse event when joya == 0 and cpu_halt == 0. The triggering delta is applied to mx = my = 0 on entry.
  - MOUSE:
    - ax = mx, ay = my.
    - Each event updates mx/my and clears the idle counter.
    - Go to JOY with mx = my = 0 when joya != 0.
    - Go to JOY with mx = my = 0 when IDLE_TIMEOUT != 0 and the idle counter reaches IDLE_TIMEOUT.
    - The idle counter saturates and does not wrap.
  - HALT:
    - Entered from any state when cpu_halt == 1.
    - ax = ay = 0 and mx = my = 0. Mouse events are consumed and discarded.
    - Go to JOY on the first edge with cpu_halt == 0.
- Priority within one edge: cpu_halt > joya != 0 > mouse event > idle timeout.
  - A mouse event coincident with joya != 0 is discarded.
- joy_out:
  - MOUSE: {joy[15:6], ps2_mouse[1:0], joy[3:0]}.
  - Otherwise: joy.
  - Registered with the same one-edge latency as ax/ay.
- axis_upd:
  - Asserted for one cycle when the registered {ax, ay} differ from the previous cycle.
  - No pulse if a saturated accumulator receives a further delta in the same direction.
- mouse_active equals (state == MOUSE), registered.
- Reset mid-operation: asynchronous return to the reset values above. A pending strobe toggle is not replayed.

Test Plan:
- Reset, joya = 16'h3A_C5, no mouse activity -> after 1 edge ax = 8'hC5, ay = 8'h3A, mouse_active = 0, joy_out = joy.
- joya = 0, toggle strobe with dX = +4 (sign 0), dY = +3 -> two edges later ax = 4, ay = -3 (8'hFD), mouse_active = 1, axis_upd pulses once. joy_out[5:4] follows ps2_mouse[1:0] (set 2'b10 -> joy_out[5:4] = 2'b10).
- In MOUSE, 20 events of dX = +100 -> every delta clamped to +10, ax saturates at 127 (13th event onward) and never wraps. No axis_upd after saturation.
- In MOUSE, single event of dX = -100 (sign 1, byte 8'h9C) -> ax decreases by exactly 10.
- In MOUSE with ax = 50, drive joya = 16'h0010 together with a mouse event -> next outputs ax = 8'h10, ay = 0, mouse_active = 0, event discarded, mx cleared. A later event with joya = 0 restarts from 0.
- cpu_halt = 1 while in MOUSE with ax = 30 -> ax = ay = 0 after 1 edge, events ignored. Deassert -> state JOY.
- IDLE_TIMEOUT = 8, one event then idle -> fall back to JOY after 8 idle cycles.
- Reset asserted mid-MOUSE -> outputs 0 immediately.
